mdc_multistream_ctrl_fsm: RTL and testbench

//  Main sequencing FSM for MDC HWPEs. It generalises the single-stream fixed FSM to N_IN source
//  and N_OUT sink streamers, processed over nb_iter+1 tiles.
//  Per tile it re-bases every stream address (base + tile*stride), starts all streamers and the

---
 rtl/mdc_multistream_ctrl_fsm.sv | 273 +++++++++++++++++++++++++++
 tb/tb_mdc_multistream_ctrl_fsm.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdc_multistream_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// mdc_multistream_ctrl_fsm
//   Main sequencing FSM for MDC HWPEs. It drives N_IN source and N_OUT sink
//   streamers plus the engine over nb_iter+1 tiles. For each tile it re-bases
//   every stream address (base + tile*stride, wrapping at 2^AW), starts all
//   streamers and the engine together, and counts sink handshakes against a
//   per-sink limit. After the last tile it pulses done_o.
//
//   Optional feature macro: MDC_CTRL_PERF_CNT_EN
//     defined   -> perf_cycles_o is a 32-bit saturating count of busy cycles,
//                  zeroed at job acceptance and by clear_i.
//     undefined -> perf_cycles_o tied to 0, no counter logic.
//
// Ports (N_S = N_IN+N_OUT, stream k<N_IN is a source, k>=N_IN a sink):
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   clear_i              synchronous soft clear, overrides everything
//   start_i              job trigger pulse (only honoured in IDLE)
//   nb_iter_i            number of tiles minus 1
//   base_addr_i          per-stream base address   (N_S x AW, flat)
//   stride_i             per-stream tile increment (N_S x AW, flat)
//   cnt_limit_i          per-sink handshakes per tile minus 1 (N_OUT x CNT_W)
//   strm_ready_i         streamer ready to accept a start
//   out_hs_i             sink valid&ready this cycle
//   strm_req_start_o     streamer start strobe (same cycle as ready)
//   strm_addr_o          current tile address per stream
//   eng_start_o          engine start strobe
//   eng_clear_o          engine clear pulse on job acceptance
//   busy_o               job in progress
//   done_o               job-complete pulse
//   tile_idx_o           current tile index
//   perf_cycles_o        busy cycle count (see macro above)
// -----------------------------------------------------------------------------

// Per-sink handshake counter. Completion is flagged on the handshake that
// arrives with count==limit; later handshakes are ignored until cleared.
module mdc_sink_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             hs_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             done_o,
  output logic             fin_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             hit;

  assign hit    = en_i & hs_i & ~done_q;
  assign fin_o  = hit & (cnt_q == limit_i);
  assign done_o = done_q;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (clr_i) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (fin_o) begin
      done_d = 1'b1;
    end else if (hit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

`ifndef SYNTHESIS
  // A sink that keeps handshaking after its tile quota is a producer bug.
  a_hs_after_done: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(en_i && !clr_i && hs_i && done_q))
    else $warning("mdc_sink_cnt: handshake after sink completion ignored");
`endif

endmodule

module mdc_multistream_ctrl_fsm #(
  parameter int N_IN   = 2,
  parameter int N_OUT  = 1,
  parameter int AW     = 32,
  parameter int CNT_W  = 16,
  parameter int ITER_W = 12
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic                        start_i,
  input  logic [ITER_W-1:0]           nb_iter_i,
  input  logic [(N_IN+N_OUT)*AW-1:0]  base_addr_i,
  input  logic [(N_IN+N_OUT)*AW-1:0]  stride_i,
  input  logic [N_OUT*CNT_W-1:0]      cnt_limit_i,
  input  logic [N_IN+N_OUT-1:0]       strm_ready_i,
  input  logic [N_OUT-1:0]            out_hs_i,
  output logic [N_IN+N_OUT-1:0]       strm_req_start_o,
  output logic [(N_IN+N_OUT)*AW-1:0]  strm_addr_o,
  output logic                        eng_start_o,
  output logic                        eng_clear_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [ITER_W-1:0]           tile_idx_o,
  output logic [31:0]                 perf_cycles_o
);

  localparam int N_S = N_IN + N_OUT;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STARTING,
    S_COMPUTE,
    S_TILE_DONE,
    S_FINISHED
  } state_e;

  state_e                        state_q, state_d;
  logic [ITER_W-1:0]             tile_q, tile_d;
  logic [ITER_W-1:0]             nb_iter_q, nb_iter_d;
  logic [N_S-1:0][AW-1:0]        addr_q, addr_d;
  logic [N_S-1:0][AW-1:0]        stride_q, stride_d;
  logic [N_OUT-1:0][CNT_W-1:0]   limit_q, limit_d;
  logic                          eng_clear_q, eng_clear_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;

  logic                          go;
  logic                          sink_en, sink_clr;
  logic [N_OUT-1:0]              sink_done, sink_fin;
  logic                          all_done;

  // Start strobes are Mealy so a ready streamer is kicked in the same cycle.
  assign go = (state_q == S_STARTING) && (&strm_ready_i);

  // Counters only live in COMPUTE; holding them clear elsewhere means stray
  // handshakes outside the window can never leak into the next tile.
  assign sink_en  = (state_q == S_COMPUTE);
  assign sink_clr = clear_i | ~sink_en;

  generate
    for (genvar j = 0; j < N_OUT; j++) begin : g_sink
      mdc_sink_cnt #(.CNT_W(CNT_W)) u_sink (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (sink_clr),
        .en_i    (sink_en),
        .hs_i    (out_hs_i[j]),
        .limit_i (limit_q[j]),
        .done_o  (sink_done[j]),
        .fin_o   (sink_fin[j])
      );
    end
  endgenerate

  // A sink counts as complete if it already was, or finishes this cycle, so
  // simultaneous final handshakes on several sinks close the tile together.
  assign all_done = &(sink_done | sink_fin);

  always_comb begin
    state_d     = state_q;
    tile_d      = tile_q;
    nb_iter_d   = nb_iter_q;
    addr_d      = addr_q;
    stride_d    = stride_q;
    limit_d     = limit_q;
    eng_clear_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          nb_iter_d   = nb_iter_i;
          limit_d     = cnt_limit_i;
          stride_d    = stride_i;
          addr_d      = base_addr_i;
          tile_d      = '0;
          eng_clear_d = 1'b1;
          state_d     = S_STARTING;
        end
      end
      S_STARTING: begin
        if (go) state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (all_done) state_d = S_TILE_DONE;
      end
      S_TILE_DONE: begin
        if (tile_q == nb_iter_q) begin
          state_d = S_FINISHED;
        end else begin
          tile_d = tile_q + 1'b1;
          for (int k = 0; k < N_S; k++) addr_d[k] = addr_q[k] + stride_q[k];
          state_d = S_STARTING;
        end
      end
      S_FINISHED: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    // Soft clear aborts the job; stream addresses deliberately stay put.
    if (clear_i) begin
      state_d     = S_IDLE;
      tile_d      = '0;
      eng_clear_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FINISHED);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      tile_q      <= '0;
      nb_iter_q   <= '0;
      addr_q      <= '0;
      stride_q    <= '0;
      limit_q     <= '0;
      eng_clear_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tile_q      <= tile_d;
      nb_iter_q   <= nb_iter_d;
      addr_q      <= addr_d;
      stride_q    <= stride_d;
      limit_q     <= limit_d;
      eng_clear_q <= eng_clear_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign strm_req_start_o = {N_S{go}};
  assign eng_start_o      = go;
  assign strm_addr_o      = addr_q;
  assign eng_clear_o      = eng_clear_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign tile_idx_o       = tile_q;

`ifdef MDC_CTRL_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (clear_i || (state_q == S_IDLE && start_i)) begin
      perf_d = '0;
    end else if (busy_q && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) perf_q <= '0;
    else         perf_q <= perf_d;
  end

  assign perf_cycles_o = perf_q;
`else
  assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_mdc_multistream_ctrl_fsm.sv
// Self-checking bench for mdc_multistream_ctrl_fsm with 2 sources and 2 sinks.
// The reference model works per job: expected addresses are base + t*stride,
// each sink finishes after limit+1 handshakes counted inside the compute
// window, and done follows the closing handshake by two cycles.
module tb_mdc_multistream_ctrl_fsm;

  localparam int N_IN   = 2;
  localparam int N_OUT  = 2;
  localparam int AW     = 32;
  localparam int CNT_W  = 16;
  localparam int ITER_W = 12;
  localparam int N_S    = N_IN + N_OUT;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic                   clear_i;
  logic                   start_i;
  logic [ITER_W-1:0]      nb_iter_i;
  logic [N_S*AW-1:0]      base_addr_i;
  logic [N_S*AW-1:0]      stride_i;
  logic [N_OUT*CNT_W-1:0] cnt_limit_i;
  logic [N_S-1:0]         strm_ready_i;
  logic [N_OUT-1:0]       out_hs_i;
  logic [N_S-1:0]         strm_req_start_o;
  logic [N_S*AW-1:0]      strm_addr_o;
  logic                   eng_start_o;
  logic                   eng_clear_o;
  logic                   busy_o;
  logic                   done_o;
  logic [ITER_W-1:0]      tile_idx_o;
  logic [31:0]            perf_cycles_o;

  mdc_multistream_ctrl_fsm #(
    .N_IN(N_IN), .N_OUT(N_OUT), .AW(AW), .CNT_W(CNT_W), .ITER_W(ITER_W)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .clear_i          (clear_i),
    .start_i          (start_i),
    .nb_iter_i        (nb_iter_i),
    .base_addr_i      (base_addr_i),
    .stride_i         (stride_i),
    .cnt_limit_i      (cnt_limit_i),
    .strm_ready_i     (strm_ready_i),
    .out_hs_i         (out_hs_i),
    .strm_req_start_o (strm_req_start_o),
    .strm_addr_o      (strm_addr_o),
    .eng_start_o      (eng_start_o),
    .eng_clear_o      (eng_clear_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .tile_idx_o       (tile_idx_o),
    .perf_cycles_o    (perf_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;
  logic [AW-1:0] cfg_base   [N_S];
  logic [AW-1:0] cfg_stride [N_S];
  int            cfg_lim    [N_OUT];
  int            exp_busy;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic to_neg();
    @(negedge clk_i);
  endtask

  task automatic to_next();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [AW-1:0] exp_addr(input int k, input int t);
    logic [AW-1:0] tt;
    tt = AW'(t);
    return cfg_base[k] + tt * cfg_stride[k];
  endfunction

  function automatic logic [31:0] exp_perf(input int n);
`ifdef MDC_CTRL_PERF_CNT_EN
    return 32'(n);
`else
    return 32'(n) & 32'h0;
`endif
  endfunction

  task automatic rand_cfg();
    for (int k = 0; k < N_S; k++) begin
      cfg_base[k]   = $urandom;
      cfg_stride[k] = $urandom;
    end
    for (int j = 0; j < N_OUT; j++) cfg_lim[j] = $urandom_range(7);
  endtask

  // Runs one job; clr_tile>=0 aborts with clear_i on the clr_hs-th counted
  // sink0 handshake of that tile. extra = handshakes pushed at finished sinks.
  task automatic run_job(input int nb, input int rdy_delay, input int hs_pct,
                         input int extra, input int clr_tile, input int clr_hs);
    int cnt [N_OUT];
    bit comp [N_OUT];
    int tot0, ex, dly, cyc;
    bit first, started, all_c, do_clr;

    exp_busy = 0;
    nb_iter_i = ITER_W'(nb);
    for (int k = 0; k < N_S; k++) begin
      base_addr_i[k*AW +: AW] = cfg_base[k];
      stride_i[k*AW +: AW]    = cfg_stride[k];
    end
    for (int j = 0; j < N_OUT; j++) cnt_limit_i[j*CNT_W +: CNT_W] = CNT_W'(cfg_lim[j]);
    start_i      = 1'b1;
    out_hs_i     = N_OUT'($urandom);
    strm_ready_i = N_S'($urandom);
    to_neg();
    chk("idle_busy", busy_o, 0);
    chk("idle_req", strm_req_start_o, 0);
    to_next();
    start_i = 1'b0;
    // Configuration is don't-care once accepted.
    nb_iter_i   = ITER_W'($urandom);
    base_addr_i = {$urandom, $urandom, $urandom, $urandom};
    stride_i    = {$urandom, $urandom, $urandom, $urandom};
    cnt_limit_i = N_OUT*CNT_W'($urandom);

    for (int t = 0; t <= nb; t++) begin
      first = 1'b1; started = 1'b0; dly = rdy_delay;
      while (!started) begin
        out_hs_i = N_OUT'($urandom);
        if (dly > 0) begin
          strm_ready_i = N_S'($urandom) & ~N_S'(2);
          dly--;
        end else begin
          strm_ready_i = '1;
        end
        to_neg();
        exp_busy++;
        chk("start_busy", busy_o, 1);
        chk("eng_clear", eng_clear_o, (t == 0 && first));
        if (&strm_ready_i) begin
          chk("req_start", strm_req_start_o, {N_S{1'b1}});
          chk("eng_start", eng_start_o, 1);
          chk("tile_idx", tile_idx_o, t);
          for (int k = 0; k < N_S; k++)
            chk("strm_addr", strm_addr_o[k*AW +: AW], exp_addr(k, t));
          started = 1'b1;
        end else begin
          chk("no_req_start", strm_req_start_o, 0);
          chk("no_eng_start", eng_start_o, 0);
        end
        first = 1'b0;
        to_next();
      end

      for (int j = 0; j < N_OUT; j++) begin cnt[j] = 0; comp[j] = 1'b0; end
      tot0 = 0; ex = extra; cyc = 0; all_c = 1'b0;
      while (!all_c) begin
        if (cyc > 2000) begin
          chk("compute_timeout", 0, 1);
          return;
        end
        for (int j = 0; j < N_OUT; j++) begin
          if (comp[j]) begin
            out_hs_i[j] = (ex > 0);
            if (ex > 0) ex--;
          end else begin
            out_hs_i[j] = ($urandom_range(99) < hs_pct);
          end
        end
        strm_ready_i = N_S'($urandom);
        do_clr  = (t == clr_tile) && out_hs_i[0] && !comp[0] && (tot0 + 1 == clr_hs);
        clear_i = do_clr;
        to_neg();
        exp_busy++;
        chk("comp_busy", busy_o, 1);
        chk("comp_done", done_o, 0);
        chk("comp_req", strm_req_start_o, 0);
        for (int j = 0; j < N_OUT; j++) begin
          if (out_hs_i[j] && !comp[j]) begin
            cnt[j]++;
            if (j == 0) tot0++;
            if (cnt[j] == cfg_lim[j] + 1) comp[j] = 1'b1;
          end
        end
        all_c = 1'b1;
        for (int j = 0; j < N_OUT; j++) if (!comp[j]) all_c = 1'b0;
        to_next();
        clear_i = 1'b0;
        cyc++;
        if (do_clr) begin
          out_hs_i = '0;
          to_neg();
          chk("clr_busy", busy_o, 0);
          chk("clr_done", done_o, 0);
          chk("clr_tile", tile_idx_o, 0);
          chk("clr_perf", perf_cycles_o, exp_perf(0));
          for (int k = 0; k < N_S; k++)
            chk("clr_addr_held", strm_addr_o[k*AW +: AW], exp_addr(k, t));
          to_next();
          to_neg();
          chk("clr_no_done", done_o, 0);
          to_next();
          return;
        end
      end

      // Tile-done cycle: nothing may start even with every streamer ready.
      out_hs_i     = N_OUT'($urandom);
      strm_ready_i = '1;
      to_neg();
      exp_busy++;
      chk("td_busy", busy_o, 1);
      chk("td_done", done_o, 0);
      chk("td_req", strm_req_start_o, 0);
      to_next();
    end

    out_hs_i = N_OUT'($urandom);
    to_neg();
    exp_busy++;
    chk("done_pulse", done_o, 1);
    chk("fin_busy", busy_o, 1);
    to_next();
    to_neg();
    chk("done_low", done_o, 0);
    chk("idle_after", busy_o, 0);
    chk("perf", perf_cycles_o, exp_perf(exp_busy));
    to_next();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; nb_iter_i = '0;
    base_addr_i = '0; stride_i = '0; cnt_limit_i = '0;
    strm_ready_i = '1; out_hs_i = '0;
    repeat (2) to_next();
    to_neg();
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_addr", strm_addr_o, 0);
    chk("rst_tile", tile_idx_o, 0);
    chk("rst_eng_clear", eng_clear_o, 0);
    chk("rst_req", strm_req_start_o, 0);
    chk("rst_perf", perf_cycles_o, 0);
    to_next();
    rst_ni = 1'b1;
    to_next();

    // Single tile, 16 handshakes on both sinks at once.
    rand_cfg(); cfg_lim[0] = 15; cfg_lim[1] = 15;
    run_job(0, 0, 100, 0, -1, 0);

    // Three tiles with a known base/stride on stream 0.
    rand_cfg(); cfg_base[0] = 32'h1000; cfg_stride[0] = 32'h400;
    run_job(2, 0, 70, 0, -1, 0);

    // Streamer 1 holds off for 10 cycles.
    rand_cfg();
    run_job(0, 10, 60, 0, -1, 0);

    // Limits 3/7: sink0 sees 2 surplus handshakes after completing.
    rand_cfg(); cfg_lim[0] = 3; cfg_lim[1] = 7;
    run_job(0, 0, 100, 2, -1, 0);

    // Clear on the 5th handshake of tile 1, then a clean job.
    rand_cfg(); cfg_lim[0] = 9; cfg_lim[1] = 9;
    run_job(2, 1, 100, 0, 1, 5);
    rand_cfg();
    run_job(1, 2, 50, 0, -1, 0);

    // Address wrap at 2^32 on tile 1.
    rand_cfg(); cfg_base[0] = 32'hFFFF_FC00; cfg_stride[0] = 32'h400;
    run_job(1, 0, 80, 0, -1, 0);

    // Asynchronous reset mid-job.
    rand_cfg();
    nb_iter_i = 1;
    for (int k = 0; k < N_S; k++) base_addr_i[k*AW +: AW] = cfg_base[k] | 32'h1;
    start_i = 1'b1;
    to_next();
    start_i = 1'b0; strm_ready_i = '0;
    to_next();
    rst_ni = 1'b0;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_addr", strm_addr_o, 0);
    chk("arst_eng_clear", eng_clear_o, 0);
    to_next();
    rst_ni = 1'b1;
    to_next();

    // Randomized jobs.
    for (int r = 0; r < 6; r++) begin
      rand_cfg();
      run_job($urandom_range(3), $urandom_range(3), 30 + $urandom_range(60), 0, -1, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
